// File: rtl/narvie_uart_pkg.sv
// Shared definitions for the narvie UART receive path: default clock and
// baud rate, the clocks-per-bit helper, the byte FSM state encoding and the
// NOP instruction word (the host sends it as 13 00 00 00).
// No ports.
package narvie_uart_pkg;

  localparam int          DEFAULT_CLK_HZ = 12_000_000;
  localparam int          DEFAULT_BAUD   = 115_200;
  localparam logic [31:0] NOP_WORD       = 32'h1300_0000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser on rx followed by the byte
// FSM (IDLE -> START -> DATA -> STOP).
// Ports:
//   clk12  in   system clock
//   rstn   in   synchronous active-low reset
//   rx     in   asynchronous UART line, idle high
//   data   out  last received byte, LSB arrives first on the wire
//   valid  out  combinational pulse in the cycle the stop bit samples high
//   err    out  combinational pulse in the cycle the stop bit samples low
//   busy   out  FSM is outside IDLE (a byte is being received)
module uart_rx_byte
  import narvie_uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       clk12,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int                CPB     = clks_per_bit(CLK_HZ, BAUD);
  localparam int                CNT_W   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CPB - 1);

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_p2;
  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;

  // Stage p0/p1: synchroniser; rx_p1 is the synced line, rx_p2 its previous
  // value for falling-edge detection. Idle-high reset keeps reset itself
  // from looking like a start edge.
  always_ff @(posedge clk12) begin
    if (!rstn) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_p2   <= rx_p1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_ff @(posedge clk12) begin
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    valid       = 1'b0;
    err         = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_p2 && !rx_p1) begin
          state_nxt = START;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was a glitch.
        if (cnt == HALF_M1) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_p1, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          valid     = rx_p1;
          err       = !rx_p1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign data = shift;
  assign busy = (state != IDLE);

endmodule

// File: rtl/instr_frame_rx.sv
// narvie command front end: receives 8N1 bytes, packs every four valid bytes
// big-endian (first byte -> [31:24]) into a 32-bit instruction word and
// pulses instruction_rcv for one cycle when the word is presented.
// Optional feature macro: RX_TIMEOUT_EN -- when defined, a partial word left
// idle for TIMEOUT_CLKS cycles is silently dropped.
// Ports:
//   clk12            in   system clock
//   rstn             in   synchronous active-low reset
//   rx               in   asynchronous UART line, idle high
//   instruction      out  last completed word (holds until the next one)
//   instruction_rcv  out  one-cycle pulse, instruction valid from this cycle
//   frame_err        out  one-cycle pulse after a low stop-bit sample
module instr_frame_rx
  import narvie_uart_pkg::*;
#(
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int TIMEOUT_CLKS = 12000
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instruction,
  output logic        instruction_rcv,
  output logic        frame_err
);

  logic [7:0]  byte_data;
  logic        byte_vld;
  logic        byte_err;
  logic        rx_busy;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sh;
  logic        drop_partial;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_byte (
    .clk12 (clk12),
    .rstn  (rstn),
    .rx    (rx),
    .data  (byte_data),
    .valid (byte_vld),
    .err   (byte_err),
    .busy  (rx_busy)
  );

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Counts only while a partial word waits and the line is idle; any start
  // edge moves the FSM out of IDLE and restarts the count.
  always_ff @(posedge clk12) begin
    if (!rstn || rx_busy || (byte_cnt == 2'd0) || drop_partial) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign drop_partial = (idle_cnt == IDLE_W'(TIMEOUT_CLKS));
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CLKS, rx_busy};
  assign drop_partial   = 1'b0;
`endif

  // Stage p1: word assembly. Only the three older bytes are kept; the fourth
  // goes straight into instruction so the output moves once per word.
  always_ff @(posedge clk12) begin
    if (!rstn) begin
      byte_cnt        <= '0;
      word_sh         <= '0;
      instruction     <= '0;
      instruction_rcv <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      instruction_rcv <= 1'b0;
      frame_err       <= byte_err;
      if (byte_err) begin
        byte_cnt <= '0;
      end else if (byte_vld) begin
        word_sh  <= {word_sh[15:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          instruction     <= {word_sh, byte_data};
          instruction_rcv <= 1'b1;
        end
      end else if (drop_partial) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_frame_rx.sv
// Self-checking bench for instr_frame_rx: directed scenarios plus random
// words, compared against a byte/word reference model with exact pulse timing.
module tb_instr_frame_rx;
  import narvie_uart_pkg::*;

  localparam int CLK_HZ       = 12_000_000;
  localparam int BAUD         = 115_200;
  localparam int TIMEOUT_CLKS = 12000;
  localparam int CPB          = CLK_HZ / BAUD;
  // Start bit driven -> 2 sync flops + 1 edge-detect cycle, half a bit to the
  // start sample, 8 data bits, one stop bit, then the registered pulse.
  localparam int LAT          = 3 + CPB / 2 + 9 * CPB;

  logic        clk12 = 1'b0;
  logic        rstn;
  logic        rx;
  logic [31:0] instruction;
  logic        instruction_rcv;
  logic        frame_err;

  instr_frame_rx #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk12           (clk12),
    .rstn            (rstn),
    .rx              (rx),
    .instruction     (instruction),
    .instruction_rcv (instruction_rcv),
    .frame_err       (frame_err)
  );

  always #5 clk12 = ~clk12;

  typedef struct {
    bit          is_err;
    logic [31:0] word;
    int          cyc;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  partial[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_word = 32'h0;
  ev_t         mon_e;

  always @(posedge clk12) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every cycle either an expected pulse is due, or nothing may pulse
  // and instruction must hold the last completed word.
  always @(negedge clk12) begin
    if (mon_en) begin
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
        mon_e = evq.pop_front();
        if (mon_e.is_err) begin
          chk("frame_err_pulse", {31'b0, frame_err}, 32'd1);
          chk("rcv_during_err", {31'b0, instruction_rcv}, 32'd0);
        end else begin
          chk("rcv_pulse", {31'b0, instruction_rcv}, 32'd1);
          chk("err_during_rcv", {31'b0, frame_err}, 32'd0);
          model_word = mon_e.word;
        end
        chk("instruction", instruction, model_word);
      end else begin
        chk("no_pulse", {30'b0, instruction_rcv, frame_err}, 32'd0);
        chk("instruction_hold", instruction, model_word);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk12);
`ifdef RX_TIMEOUT_EN
    if (n > TIMEOUT_CLKS) partial.delete();
`endif
  endtask

  // Called at a negedge; returns at the negedge where the next bit may start.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] frame;
    ev_t        e;
    frame  = {stop_ok, b, 1'b0};
    e.cyc  = cyc + LAT;
    e.word = 32'h0;
    if (!stop_ok) begin
      partial.delete();
      e.is_err = 1'b1;
      evq.push_back(e);
    end else begin
      partial.push_back(b);
      if (partial.size() == 4) begin
        e.is_err = 1'b0;
        e.word   = {partial[0], partial[1], partial[2], partial[3]};
        partial.delete();
        evq.push_back(e);
      end
    end
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk12);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  initial begin
    rx   = 1'b1;
    rstn = 1'b0;
    repeat (4) @(negedge clk12);
    chk("reset_instruction", instruction, 32'h0);
    chk("reset_rcv", {31'b0, instruction_rcv}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    rstn = 1'b1;
    idle(20);
    mon_en = 1'b1;

    // NOP word, then two words back to back
    send_word(NOP_WORD);
    idle(50);
    send_word(32'h9300_1000);
    send_word(32'h1301_2000);
    idle(100);

    // Framing error on the second byte discards the partial word
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    idle(2 * CPB);
    send_word(32'h0102_0304);
    idle(100);

    // Start-bit glitch shorter than half a bit
    rx = 1'b0;
    repeat (20) @(negedge clk12);
    idle(200);
    send_word(32'h1122_3344);
    idle(100);

    // Random: one bad-stop byte, then random words with random gaps
    send_byte(8'($urandom), 1'b0);
    idle(2 * CPB);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(8'($urandom), 1'b1);
        idle($urandom_range(0, 300));
      end
    end

    // Long idle inside a partial word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(13000);
    send_word(32'h3344_5566);
    idle(100);

    // Reset in the middle of a byte (during the high bit 1 of 0x22)
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk12);
    rx = 1'b0;
    repeat (CPB) @(negedge clk12);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk12);
    mon_en = 1'b0;
    rstn   = 1'b0;
    @(negedge clk12);
    rstn = 1'b1;
    chk("midreset_instruction", instruction, 32'h0);
    chk("midreset_rcv", {31'b0, instruction_rcv}, 32'd0);
    chk("midreset_frame_err", {31'b0, frame_err}, 32'd0);
    partial.delete();
    model_word = 32'h0;
    idle(500);
    mon_en = 1'b1;
    send_word(32'hA0B0_C0D0);
    idle(100);

    for (int i = 0; i < 3 * LAT && evq.size() != 0; i++) @(negedge clk12);
    chk("pending_events", evq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_frame_rx.md
# instr_frame_rx

- Front end of the narvie command path: receives 8N1 UART bytes on `rx`, groups every four valid bytes into one 32-bit instruction word and pulses `instruction_rcv`.
- Feeds the top level's instruction buffer and execute trigger.
- No backpressure: a word is presented once and the consumer samples it on the pulse.
- Malformed bytes and stalled partial words are discarded so the host can resynchronise.

## Interface
Parameters:
- `CLK_HZ`, 12000000: frequency of `clk12` in Hz.
- `BAUD`, 115200: UART bit rate.
- `TIMEOUT_CLKS`, 12000: idle cycles after which a partial word is dropped (only when `RX_TIMEOUT_EN` is defined).

Ports:
- `clk12`  in  1  single system clock.
- `rstn`  in  1  reset, synchronous and active-low.
- `rx`  in  1  asynchronous UART line, idle high.
- `instruction`  out  32  last completed word.
- `instruction_rcv`  out  1  one-cycle pulse; `instruction` is valid on this cycle and afterwards.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.

## Operation
- **Synchroniser.** `rx` passes through two flops (reset value 1). All logic uses the synchronised value.
- **Bit timing.** `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division (104 at the defaults). The bit counter is wide enough for `CLKS_PER_BIT - 1`.
- **Byte FSM:**
  - IDLE: a high-to-low transition on synced rx → START, counter cleared.
  - START: at count `CLKS_PER_BIT/2 - 1`, sample the line.
    - Low → DATA.
    - High (glitch) → IDLE, nothing reported.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, 8 bits; after bit 7 → STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - High → byte valid.
    - Low → pulse `frame_err`, byte dropped.
    - Either case → IDLE. IDLE accepts a new start edge on the very next cycle.
- **Word assembly.** A 2-bit `byte_cnt` counts valid bytes.
  - Byte 0 → `[31:24]`, byte 1 → `[23:16]`, byte 2 → `[15:8]`, byte 3 → `[7:0]` (big-endian on the wire).
  - Example: the NOP is sent as 13 00 00 00 and gives 32'h13000000.
  - Bytes accumulate in an internal shift register. `instruction` changes only when a word completes, then `byte_cnt` wraps to 0.
- **Framing error.** Clears `byte_cnt`, so the partial word is discarded.
- **Reset mid-operation.** FSM returns to IDLE; `byte_cnt`, shift register and outputs are cleared. A byte already in flight is lost, and reception resumes only at the next falling edge after `rstn` goes high.
- **Pulse ownership.** `instruction_rcv` and `frame_err` never assert in the same cycle: a valid stop and a bad stop are mutually exclusive.

## Timing
- Reset values: `instruction` = 0, `instruction_rcv` = 0, `frame_err` = 0, FSM IDLE, `byte_cnt` = 0.
- Input latency: 2 cycles from the `rx` pin to the synced value.
- `instruction_rcv`: registered, high for exactly 1 cycle, in the cycle after the 4th stop bit is sampled high. `instruction` updates in that same cycle.
- `frame_err`: high for 1 cycle, in the cycle after a low stop sample.
- Word period: minimum 40 bit times, about 4.17 k cycles at the defaults. Pulses are therefore at least ~4000 cycles apart, and the consumer must finish with each word within that window.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - An idle counter runs whenever `byte_cnt != 0` and the FSM is in IDLE.
  - It resets on every start edge.
  - When it reaches `TIMEOUT_CLKS`, `byte_cnt` is cleared. No output pulse is produced.
- `RX_TIMEOUT_EN` not defined:
  - No counter exists.
  - A partial word persists indefinitely and is cleared only by reset or a framing error.

## Structure
- Shared package `narvie_uart_pkg`:
  - Default `CLK_HZ` and `BAUD`.
  - `CLKS_PER_BIT` computation.
  - Byte FSM state enum (IDLE, START, DATA, STOP).
  - `NOP_WORD` = 32'h13000000.
- Sub-module `uart_rx_byte`: synchroniser plus byte FSM, with outputs `data[7:0]`, `valid` pulse and `err` pulse.
- The top of this block adds word assembly and the optional timeout.

## Test plan
1. **NOP word.** Send 13 00 00 00 at 115200 baud after reset → one `instruction_rcv` pulse 1 cycle after the last stop sample; `instruction` = 32'h13000000.
2. **Back-to-back words.** Send 93 00 10 00 then 13 01 20 00 with no idle gap → two pulses; `instruction` = 32'h93001000, then 32'h13012000.
3. **Framing error.** Send AA BB with a low stop bit on BB, then 01 02 03 04 → `frame_err` pulses once, no pulse for the broken frame, then `instruction` = 32'h01020304.
4. **Start-bit glitch.** Drive `rx` low for 20 cycles → no byte counted, no error; a following word 11 22 33 44 decodes as 32'h11223344.
5. **Timeout.** Build with `RX_TIMEOUT_EN`, send 11 22, idle 13000 cycles, send 33 44 55 66 → a single pulse, `instruction` = 32'h33445566. Without the macro the same stimulus gives 32'h11223344 after 33 44.
6. **Reset mid-word.** Send 11 22, assert `rstn` low for 1 cycle mid-byte, then send A0 B0 C0 D0 → `instruction` reads 0 right after reset, then 32'hA0B0C0D0 with exactly one pulse.
